li_upsampler_4x: RTL and testbench

- Stereo linear-interpolation upsampler that converts 48 kHz audio to 192 kHz (4x).
- Sits directly upstream of the 192 kHz stereo/FM block and drives its LI_LEFT / LI_RIGHT inputs.
- Takes one 18-bit signed sample pair per clken_48 and emits four linearly interpolated pairs, one per clken_192.
- Handshakes with the downstream block through ready_li, which is sampled together with clken_192.

---
 rtl/li_upsampler_4x_pkg.sv | 13 +
 rtl/li_upsampler_4x_channel.sv | 58 +++++
 rtl/li_upsampler_4x.sv | 98 +++++++++
 tb/tb_li_upsampler_4x.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/li_upsampler_4x_pkg.sv
// Shared widths and FSM encoding for the 48 kHz -> 192 kHz linear-interpolation upsampler.
package li_upsampler_4x_pkg;

  localparam int DATA_W_DEF     = 18;
  localparam int LOG2_RATIO_DEF = 2;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_RUN   = 2'd2
  } li_state_e;

endpackage

// File: rtl/li_upsampler_4x_channel.sv
// One interpolation datapath: prev/curr sample registers and the registered
// output prev + floor(phase * (curr - prev) / 2^LOG2_RATIO).
module li_channel #(
  parameter int DATA_W     = 18,
  parameter int LOG2_RATIO = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  update,
  input  logic [LOG2_RATIO-1:0] phase,
  input  logic [DATA_W-1:0]     sample_in,
  output logic [DATA_W-1:0]     li_out
);

  localparam int PW = DATA_W + 1 + LOG2_RATIO;

  logic [DATA_W-1:0]     prev_q, prev_d;
  logic [DATA_W-1:0]     curr_q, curr_d;
  logic [DATA_W-1:0]     out_q, out_d;
  logic signed [DATA_W:0] diff;
  logic signed [PW-1:0]  product;
  logic [DATA_W-1:0]     incr;

  always_comb begin
    prev_d = prev_q;
    curr_d = curr_q;
    if (load) begin
      prev_d = curr_q;
      curr_d = sample_in;
    end

    diff    = $signed({curr_q[DATA_W-1], curr_q}) - $signed({prev_q[DATA_W-1], prev_q});
    product = $signed({{LOG2_RATIO{diff[DATA_W]}}, diff}) *
              $signed({{(DATA_W + 1){1'b0}}, phase});
    // Arithmetic shift floors; the result always lies between prev and curr,
    // so dropping the upper bits cannot lose information.
    incr    = DATA_W'(product >>> LOG2_RATIO);

    out_d = out_q;
    if (update) out_d = prev_q + incr;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      prev_q <= '0;
      curr_q <= '0;
      out_q  <= '0;
    end else begin
      prev_q <= prev_d;
      curr_q <= curr_d;
      out_q  <= out_d;
    end
  end

  assign li_out = out_q;

endmodule

// File: rtl/li_upsampler_4x.sv
// Stereo 4x linear-interpolation upsampler: shared phase counter, start-up FSM
// and output strobe around two independent channel datapaths.
//
//   state    | meaning
//   ST_EMPTY | no sample loaded since reset
//   ST_ONE   | one sample loaded; prev still holds the reset value
//   ST_RUN   | prev and curr both real samples; output is valid audio
module li_upsampler_4x
  import li_upsampler_4x_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int LOG2_RATIO = LOG2_RATIO_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clken_48,
  input  logic              clken_192,
  input  logic [DATA_W-1:0] LEFT_IN,
  input  logic [DATA_W-1:0] RIGHT_IN,
  output logic [DATA_W-1:0] LI_LEFT,
  output logic [DATA_W-1:0] LI_RIGHT,
  output logic              ready_li,
  output logic              li_strobe
);

  localparam logic [LOG2_RATIO-1:0] PHASE_MAX = '1;

  logic [LOG2_RATIO-1:0] phase_q, phase_d;
  logic                  stb_q, stb_d;
  logic                  strobe_q, strobe_d;
  li_state_e             state_q;
  logic                  ready_q;

  always_comb begin
    phase_d = phase_q;
    // A load restarts the interpolation; without one the phase saturates
    // so a missing 48 kHz pulse holds the last value instead of wrapping.
    if (clken_48)
      phase_d = '0;
    else if (clken_192 && (phase_q != PHASE_MAX))
      phase_d = phase_q + 1'b1;

    stb_d    = clken_192;
    strobe_d = stb_q;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      phase_q  <= '0;
      stb_q    <= 1'b0;
      strobe_q <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      stb_q    <= stb_d;
      strobe_q <= strobe_d;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_EMPTY;
      ready_q <= 1'b0;
    end else begin
      if (clken_48) begin
        case (state_q)
          ST_EMPTY: state_q <= ST_ONE;
          ST_ONE:   state_q <= ST_RUN;
          default:  state_q <= ST_RUN;
        endcase
      end
      if (stb_q && (state_q == ST_RUN)) ready_q <= 1'b1;
    end
  end

  li_channel #(.DATA_W(DATA_W), .LOG2_RATIO(LOG2_RATIO)) u_left (
    .clock     (clock),
    .reset     (reset),
    .load      (clken_48),
    .update    (stb_q),
    .phase     (phase_q),
    .sample_in (LEFT_IN),
    .li_out    (LI_LEFT)
  );

  li_channel #(.DATA_W(DATA_W), .LOG2_RATIO(LOG2_RATIO)) u_right (
    .clock     (clock),
    .reset     (reset),
    .load      (clken_48),
    .update    (stb_q),
    .phase     (phase_q),
    .sample_in (RIGHT_IN),
    .li_out    (LI_RIGHT)
  );

  assign ready_li  = ready_q;
  assign li_strobe = strobe_q;

endmodule

// File: tb/tb_li_upsampler_4x.sv
// Bench for li_upsampler_4x: directed start-up/boundary sequences then random
// stereo streams, compared against an arithmetic interpolation model.
module tb_li_upsampler_4x;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        clken_48 = 1'b0;
  logic        clken_192 = 1'b0;
  logic [17:0] LEFT_IN = '0;
  logic [17:0] RIGHT_IN = '0;
  logic [17:0] LI_LEFT;
  logic [17:0] LI_RIGHT;
  logic        ready_li;
  logic        li_strobe;

  int errors = 0;
  int checks = 0;

  // Reference model state (integer arithmetic on the sample history)
  int m_prev_l, m_curr_l, m_prev_r, m_curr_r;
  int m_phase, m_loads;
  int exp_l, exp_r;
  int exp_rdy;

  li_upsampler_4x dut (
    .clock     (clock),
    .reset     (reset),
    .clken_48  (clken_48),
    .clken_192 (clken_192),
    .LEFT_IN   (LEFT_IN),
    .RIGHT_IN  (RIGHT_IN),
    .LI_LEFT   (LI_LEFT),
    .LI_RIGHT  (LI_RIGHT),
    .ready_li  (ready_li),
    .li_strobe (li_strobe)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int interp(input int p, input int c, input int ph);
    int num, q;
    num = ph * (c - p);
    q = num / 4;
    if (num < 0 && (num % 4) != 0) q = q - 1;
    return p + q;
  endfunction

  task automatic model_reset();
    m_prev_l = 0; m_curr_l = 0; m_prev_r = 0; m_curr_r = 0;
    m_phase = 0; m_loads = 0;
    exp_l = 0; exp_r = 0; exp_rdy = 0;
  endtask

  task automatic model_load(input int l, input int r);
    m_prev_l = m_curr_l; m_curr_l = l;
    m_prev_r = m_curr_r; m_curr_r = r;
    m_phase = 0;
    m_loads++;
  endtask

  task automatic check_hold(input string where);
    chk({where, "_left"},  $signed(LI_LEFT),  exp_l);
    chk({where, "_right"}, $signed(LI_RIGHT), exp_r);
    chk({where, "_strobe"}, li_strobe, 0);
    chk({where, "_ready"},  ready_li,  exp_rdy);
  endtask

  // One 192 kHz period, entered and left on a falling edge.
  task automatic period(input bit c48, input int l, input int r, input int gap);
    logic [31:0] lv, rv;
    lv = l; rv = r;
    clken_192 = 1'b1;
    clken_48  = c48;
    LEFT_IN   = lv[17:0];
    RIGHT_IN  = rv[17:0];
    if (c48) model_load(l, r);
    else if (m_phase < 3) m_phase++;
    @(negedge clock);
    clken_192 = 1'b0;
    clken_48  = 1'b0;
    check_hold("pre_update");
    @(negedge clock);
    exp_l = interp(m_prev_l, m_curr_l, m_phase);
    exp_r = interp(m_prev_r, m_curr_r, m_phase);
    if (m_loads >= 2) exp_rdy = 1;
    chk("li_left",  $signed(LI_LEFT),  exp_l);
    chk("li_right", $signed(LI_RIGHT), exp_r);
    chk("li_strobe", li_strobe, 1);
    chk("ready_li",  ready_li,  exp_rdy);
    for (int i = 0; i < gap; i++) begin
      @(negedge clock);
      check_hold("idle");
    end
  endtask

  task automatic load_only(input int l, input int r);
    logic [31:0] lv, rv;
    lv = l; rv = r;
    clken_48 = 1'b1;
    LEFT_IN  = lv[17:0];
    RIGHT_IN = rv[17:0];
    model_load(l, r);
    @(negedge clock);
    clken_48 = 1'b0;
    check_hold("load_only");
    @(negedge clock);
    check_hold("load_only2");
  endtask

  task automatic mid_reset();
    reset = 1'b0;
    #1;
    chk("rst_left",   $signed(LI_LEFT),  0);
    chk("rst_right",  $signed(LI_RIGHT), 0);
    chk("rst_ready",  ready_li,  0);
    chk("rst_strobe", li_strobe, 0);
    model_reset();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
  endtask

  task automatic frame(input int l, input int r);
    period(1'b1, l, r, 0);
    for (int k = 0; k < 3; k++) period(1'b0, 0, 0, 0);
  endtask

  initial begin
    int l, r, gap;
    bit c48;
    model_reset();
    repeat (3) @(negedge clock);
    chk("reset_left",   $signed(LI_LEFT),  0);
    chk("reset_right",  $signed(LI_RIGHT), 0);
    chk("reset_ready",  ready_li,  0);
    chk("reset_strobe", li_strobe, 0);
    reset = 1'b1;
    @(negedge clock);

    // Ramp, sign/floor and full-scale step sequences
    frame(0, 0);
    frame(100, 3);
    frame(100, 0);
    frame(131071, -3);
    frame(-131072, 0);
    // Missing 48 kHz pulse: four extra periods hold at phase 3
    for (int k = 0; k < 4; k++) period(1'b0, 0, 0, 1);
    frame(500, -500);
    load_only(-7, 9);
    frame(20, 40);

    // Reset while running, then re-prime
    mid_reset();
    frame(1000, -1000);
    frame(2000, 2000);

    for (int n = 0; n < 240; n++) begin
      c48 = ((n % 4) == 0) && ($urandom_range(0, 7) != 0);
      l = int'($urandom_range(0, 262143)) - 131072;
      r = int'($urandom_range(0, 262143)) - 131072;
      gap = int'($urandom_range(0, 2));
      period(c48, l, r, gap);
      if (n == 150) mid_reset();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
